// File: rtl/qsn_pkg.sv
// qsn_pkg: shared constants and types for the QSN sharing front end.
package qsn_pkg;

    localparam int QSN_Z     = 15;
    localparam int QSN_SEL_W = 4;
    localparam int QSN_LAT   = 1;

    typedef logic [QSN_Z-1:0]     qsn_vec_t;
    typedef logic [QSN_SEL_W-1:0] qsn_sel_t;
    typedef logic                 qsn_src_t;

    // A shift factor outside the circulant cannot be applied; it is reported
    // separately and replaced by a zero shift so the data still flows.
    function automatic logic qsn_shift_bad(input qsn_sel_t s);
        return (s >= QSN_SEL_W'(QSN_Z));
    endfunction

endpackage

// File: rtl/qsn_arb_fifo.sv
// qsn_arb_fifo: synchronous FIFO with occupancy count and no write-to-read
// bypass. Storage is cleared on reset so the head reads zero while empty.
module qsn_arb_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                         sys_clk,
    input  logic                         rstn,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_din,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_dout,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;

    assign w_do_pop = i_pop && (r_count != '0);
    assign o_dout   = r_mem[r_rd_ptr];
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;

    // Storage and pointers; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: push and pop together leave it unchanged.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(i_push) - CW'(w_do_pop);
        end
    end

    // A push that is not matched by a pop while full would overwrite the head.
    assert property (@(posedge sys_clk) disable iff (!rstn)
        !(i_push && (r_count == CW'(DEPTH)) && !w_do_pop))
        else $error("qsn_arb_fifo: push while full");

endmodule

// File: rtl/qsn_share_arb.sv
// qsn_share_arb: round-robin sharing of one pipelined right-shift QSN between
// the VNU path (requester 0) and the CNU path (requester 1). The QSN cannot be
// stalled, so an operation is only issued when a FIFO slot is reserved for it.
// Optional build macro QSN_ARB_PERF_EN adds grant/stall counters.
//
// Handshake: a transfer happens in a cycle where reqN_valid and reqN_ready are
// both high; requesters hold valid/data/shift stable until then, and ready is
// never asserted without valid. Downstream pops the head when out_valid and
// out_ready are both high.
module qsn_share_arb
    import qsn_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        sys_clk,
    input  logic        rstn,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  qsn_vec_t    req0_data,
    input  qsn_sel_t    req0_shift,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  qsn_vec_t    req1_data,
    input  qsn_sel_t    req1_shift,
    output qsn_vec_t    qsn_sw_in,
    output qsn_sel_t    qsn_sel,
    input  qsn_vec_t    qsn_sw_out,
    output logic        out_valid,
    input  logic        out_ready,
    output qsn_vec_t    out_data,
    output qsn_src_t    out_src,
    output logic        shift_err
`ifdef QSN_ARB_PERF_EN
    ,
    output logic [15:0] perf_grant0,
    output logic [15:0] perf_grant1,
    output logic [15:0] perf_stall
`endif
);

    localparam int PIPE_LEN = 1 + QSN_LAT;
    localparam int CW       = $clog2(FIFO_DEPTH + 1);
    localparam int FW       = QSN_Z + 1;

    logic [CW-1:0]       r_credits;
    logic                r_prio;
    logic [PIPE_LEN-1:0] r_vld_pipe;
    logic [PIPE_LEN-1:0] r_src_pipe;

    logic          w_has_credit;
    logic          w_grant0;
    logic          w_grant1;
    logic          w_issue;
    logic          w_pop;
    logic          w_push;
    logic          w_fifo_empty;
    logic          w_shift_bad;
    qsn_vec_t      w_data;
    qsn_sel_t      w_shift;
    logic [FW-1:0] w_fifo_din;
    logic [FW-1:0] w_fifo_dout;
    logic [CW-1:0] w_fifo_count;

    assign w_has_credit = (r_credits != '0);

    // Grant one requester per cycle; with both asking, r_prio names the one owed a turn.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (w_has_credit) begin
            if (req0_valid && req1_valid) begin
                w_grant0 = (r_prio == 1'b0);
                w_grant1 = (r_prio == 1'b1);
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign w_issue     = w_grant0 | w_grant1;
    assign w_data      = w_grant1 ? req1_data  : req0_data;
    assign w_shift     = w_grant1 ? req1_shift : req0_shift;
    assign w_shift_bad = qsn_shift_bad(w_shift);

    // Issue stage: capture the winner into the QSN inputs and move the turn to the other side.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            qsn_sw_in <= '0;
            qsn_sel   <= '0;
            shift_err <= 1'b0;
            r_prio    <= 1'b0;
        end else if (w_issue) begin
            qsn_sw_in <= w_data;
            qsn_sel   <= w_shift_bad ? '0 : w_shift;
            r_prio    <= w_grant0;
            if (w_shift_bad) begin
                shift_err <= 1'b1;
            end
        end
    end

    // Track which QSN output cycles carry real results, and from whom.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            r_vld_pipe <= '0;
            r_src_pipe <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[PIPE_LEN-2:0], w_issue};
            r_src_pipe <= {r_src_pipe[PIPE_LEN-2:0], w_grant1};
        end
    end

    assign w_push     = r_vld_pipe[PIPE_LEN-1];
    assign w_fifo_din = {r_src_pipe[PIPE_LEN-1], qsn_sw_out};
    assign w_pop      = out_valid & out_ready;

    qsn_arb_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_din   (w_fifo_din),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign out_valid = ~w_fifo_empty;
    assign out_data  = w_fifo_dout[QSN_Z-1:0];
    assign out_src   = w_fifo_dout[QSN_Z];

    // Credits: one taken per issue, one given back per pop.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            r_credits <= CW'(FIFO_DEPTH);
        end else begin
            r_credits <= r_credits - CW'(w_issue) + CW'(w_pop);
        end
    end

    // Every slot is either free, buffered, or reserved by an operation inside the QSN.
    assert property (@(posedge sys_clk) disable iff (!rstn)
        (int'(r_credits) + int'(w_fifo_count) + $countones(r_vld_pipe)) == FIFO_DEPTH)
        else $error("qsn_share_arb: credit accounting broken");

`ifdef QSN_ARB_PERF_EN
    logic w_stall;
    assign w_stall = (req0_valid | req1_valid) & ~w_has_credit;

    // Saturating performance counters.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
            perf_stall  <= '0;
        end else begin
            if (w_grant0 && (perf_grant0 != 16'hFFFF)) perf_grant0 <= perf_grant0 + 16'd1;
            if (w_grant1 && (perf_grant1 != 16'hFFFF)) perf_grant1 <= perf_grant1 + 16'd1;
            if (w_stall  && (perf_stall  != 16'hFFFF)) perf_stall  <= perf_stall  + 16'd1;
        end
    end
`endif

endmodule
